// File: rtl/imem_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// imem_fetch_ctrl
//
// Instruction-fetch sequencer for a combinational instruction ROM. The block
// owns the fetch PC and drives it straight onto the ROM address. Each fetched
// word is registered into a one-entry output stage, which talks to decode
// through a valid/ready handshake. Execute can redirect the fetch PC. A fetch
// from a misaligned or out-of-range address raises a sticky fault. The block
// also counts every instruction that decode accepts.
//
// Parameters
//   RESET_PC   fetch address loaded at reset
//   ROM_WORDS  ROM depth in words; legal PCs are 0 .. ROM_WORDS*4-4
//
// Ports
//   clk             in   1   system clock, all state on rising edge
//   rst_n           in   1   synchronous reset, active low
//   rom_addr        out  32  ROM byte address (= fetch PC, combinational)
//   rom_data        in   32  ROM word for rom_addr, combinational
//   redirect_valid  in   1   load redirect_pc as the new fetch PC
//   redirect_pc     in   32  redirect target byte address
//   inst_valid      out  1   inst/inst_pc hold a fetched instruction
//   inst_ready      in   1   decode accepts inst this cycle
//   inst            out  32  fetched instruction word
//   inst_pc         out  32  byte address of inst
//   fault           out  1   sticky fetch fault (misaligned or out of range)
//   fetch_count     out  32  number of accepted handshakes (valid & ready)
// -----------------------------------------------------------------------------
module imem_fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned ROM_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        fault,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

  // First byte address past the end of the ROM.
  localparam logic [31:0] PC_LIMIT = 32'(ROM_WORDS * 4);

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        inst_valid_q, inst_valid_d;
  logic        fault_q, fault_d;
  logic [31:0] fetch_count_q, fetch_count_d;

  logic take;  // decode accepts the word currently presented
  logic load;  // output stage is (or becomes) free and we may fetch
  logic bad;   // current fetch PC cannot be read from the ROM

  assign take = inst_valid_q && inst_ready;
  assign load = (state_q == ST_RUN) && !redirect_valid && (!inst_valid_q || inst_ready);
  assign bad  = (fetch_pc_q[1:0] != 2'b00) || (fetch_pc_q >= PC_LIMIT);

  always_comb begin
    // NOTE: every signal gets its hold value first, so no path through the
    // block leaves one unassigned and no latch is inferred.
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    inst_d        = inst_q;
    inst_pc_d     = inst_pc_q;
    inst_valid_d  = inst_valid_q;
    fault_d       = fault_q;
    fetch_count_d = fetch_count_q;

    // A word counts as delivered even on the edge where a redirect flushes it.
    if (take) begin
      fetch_count_d = fetch_count_q + 32'd1;
    end

    // The stage drains when its word is taken and nothing refills it.
    if (take && !load) begin
      inst_valid_d = 1'b0;
    end

    unique case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (load) begin
          if (bad) begin
            // Hold fetch_pc so rom_addr shows the offending address.
            inst_valid_d = 1'b0;
            fault_d      = 1'b1;
            state_d      = ST_FAULT;
          end else begin
            inst_d       = rom_data;
            inst_pc_d    = fetch_pc_q;
            inst_valid_d = 1'b1;
            fetch_pc_d   = fetch_pc_q + 32'd4;
          end
        end
      end
      ST_FAULT: begin
        // Parked until a redirect arrives.
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase

    // A redirect overrides any fetch decision. The target is only range-checked
    // when the block first loads from it.
    if (redirect_valid) begin
      fetch_pc_d   = redirect_pc;
      inst_valid_d = 1'b0;
      fault_d      = 1'b0;
      state_d      = ST_RUN;
    end
  end

  // NOTE: state registers use non-blocking assignments, so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_BOOT;
      fetch_pc_q    <= RESET_PC;
      inst_q        <= 32'h0;
      inst_pc_q     <= 32'h0;
      inst_valid_q  <= 1'b0;
      fault_q       <= 1'b0;
      fetch_count_q <= 32'h0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      inst_q        <= inst_d;
      inst_pc_q     <= inst_pc_d;
      inst_valid_q  <= inst_valid_d;
      fault_q       <= fault_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign rom_addr    = fetch_pc_q;
  assign inst_valid  = inst_valid_q;
  assign inst        = inst_q;
  assign inst_pc     = inst_pc_q;
  assign fault       = fault_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_imem_fetch_ctrl
//
// Testbench for imem_fetch_ctrl. A behavioural ROM answers rom_addr. Each test
// pushes the (pc, word) pairs it expects decode to receive. The clocking task
// pops one entry for every handshake observed before an edge and compares it.
// Each test task also checks the visible state inline.
// -----------------------------------------------------------------------------
module tb_imem_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        fault;
  logic [31:0] fetch_count;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_popped = 0;

  always #5 clk = ~clk;

  imem_fetch_ctrl #(
    .RESET_PC (32'h0000_0000),
    .ROM_WORDS(64)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rom_addr      (rom_addr),
    .rom_data      (rom_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst          (inst),
    .inst_pc       (inst_pc),
    .fault         (fault),
    .fetch_count   (fetch_count)
  );

  // ROM contents: a few known words, a recognisable pattern elsewhere.
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: rom_word = 32'hC000_0937;
      32'h0000_0004: rom_word = 32'hA000_09B7;
      32'h0000_0008: rom_word = 32'h0000_0293;
      32'h0000_0050: rom_word = 32'hFF75_0393;
      default:       rom_word = (a < 32'h100) ? {16'hA5A5, a[15:0]} : 32'hDEAD_BEEF;
    endcase
  endfunction

  assign rom_data = rom_word(rom_addr);

  task automatic push_exp(input logic [31:0] pc);
    exp_t e;
    e.pc   = pc;
    e.word = rom_word(pc);
    sb_q.push_back(e);
  endtask

  // One clock. A handshake visible before the edge pops and compares one entry.
  task automatic tick();
    logic        hs;
    logic [31:0] seen_inst, seen_pc;
    exp_t        e;
    hs        = (inst_valid === 1'b1) && (inst_ready === 1'b1);
    seen_inst = inst;
    seen_pc   = inst_pc;
    @(posedge clk);
    #1;
    if (hs) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        n_errors++;
        $display("FAIL sb_unexpected: delivered pc=%h inst=%h, required no delivery", seen_pc, seen_inst);
      end else begin
        e = sb_q.pop_front();
        n_popped++;
        if (seen_pc !== e.pc || seen_inst !== e.word) begin
          n_errors++;
          $display("FAIL sb_delivery: got pc=%h inst=%h, required pc=%h inst=%h",
                   seen_pc, seen_inst, e.pc, e.word);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; inst_ready = 1'b0;
    tick(); tick();
    n_checks++;
    if ({inst_valid, fault, inst, inst_pc, fetch_count, rom_addr} !== {2'b00, 128'h0}) begin
      n_errors++;
      $display("FAIL reset_state: got v=%b f=%b inst=%h pc=%h cnt=%0d addr=%h, required all zero",
               inst_valid, fault, inst, inst_pc, fetch_count, rom_addr);
    end
  endtask

  task automatic test_boot_stream();
    push_exp(32'h0); push_exp(32'h4); push_exp(32'h8);
    rst_n = 1'b1; inst_ready = 1'b1;
    tick();  // BOOT cycle: nothing fetched yet
    n_checks++;
    if (inst_valid !== 1'b0 || rom_addr !== 32'h0) begin
      n_errors++;
      $display("FAIL boot_cycle: got v=%b addr=%h, required v=0 addr=0", inst_valid, rom_addr);
    end
    tick();
    n_checks++;
    if (inst_valid !== 1'b1 || inst !== 32'hC000_0937 || inst_pc !== 32'h0 || fetch_count !== 32'd0) begin
      n_errors++;
      $display("FAIL first_fetch: got v=%b inst=%h pc=%h cnt=%0d, required v=1 inst=c0000937 pc=0 cnt=0",
               inst_valid, inst, inst_pc, fetch_count);
    end
    tick();
    n_checks++;
    if (inst !== 32'hA000_09B7 || inst_pc !== 32'h4 || fetch_count !== 32'd1) begin
      n_errors++;
      $display("FAIL second_fetch: got inst=%h pc=%h cnt=%0d, required inst=a00009b7 pc=4 cnt=1",
               inst, inst_pc, fetch_count);
    end
    tick();
    n_checks++;
    if (inst !== 32'h0000_0293 || inst_pc !== 32'h8 || fetch_count !== 32'd2 || rom_addr !== 32'hC) begin
      n_errors++;
      $display("FAIL third_fetch: got inst=%h pc=%h cnt=%0d addr=%h, required inst=00000293 pc=8 cnt=2 addr=c",
               inst, inst_pc, fetch_count, rom_addr);
    end
    inst_ready = 1'b0;
  endtask

  task automatic test_stall();
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (inst_valid !== 1'b1 || inst !== 32'h0000_0293 || inst_pc !== 32'h8 ||
          rom_addr !== 32'hC || fetch_count !== 32'd2) begin
        n_errors++;
        $display("FAIL stall_hold[%0d]: got v=%b inst=%h pc=%h addr=%h cnt=%0d, required v=1 inst=00000293 pc=8 addr=c cnt=2",
                 i, inst_valid, inst, inst_pc, rom_addr, fetch_count);
      end
    end
    push_exp(32'hC);
    inst_ready = 1'b1;
    tick();
    n_checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'hC || fetch_count !== 32'd3) begin
      n_errors++;
      $display("FAIL stall_release: got v=%b pc=%h cnt=%0d, required v=1 pc=c cnt=3",
               inst_valid, inst_pc, fetch_count);
    end
  endtask

  task automatic test_redirect();
    redirect_valid = 1'b1; redirect_pc = 32'h50;  // word at 0xC is flushed but still taken
    tick();
    n_checks++;
    if (inst_valid !== 1'b0 || rom_addr !== 32'h50 || fetch_count !== 32'd4) begin
      n_errors++;
      $display("FAIL redirect_bubble: got v=%b addr=%h cnt=%0d, required v=0 addr=50 cnt=4",
               inst_valid, rom_addr, fetch_count);
    end
    redirect_valid = 1'b0;
    push_exp(32'h50);
    tick();
    n_checks++;
    if (inst_valid !== 1'b1 || inst !== 32'hFF75_0393 || inst_pc !== 32'h50 || fetch_count !== 32'd4) begin
      n_errors++;
      $display("FAIL redirect_target: got v=%b inst=%h pc=%h cnt=%0d, required v=1 inst=ff750393 pc=50 cnt=4",
               inst_valid, inst, inst_pc, fetch_count);
    end
  endtask

  task automatic test_misaligned_fault();
    redirect_valid = 1'b1; redirect_pc = 32'h102;  // flushes the 0x50 word
    tick();
    n_checks++;
    if (inst_valid !== 1'b0 || fault !== 1'b0 || rom_addr !== 32'h102 || fetch_count !== 32'd5) begin
      n_errors++;
      $display("FAIL misalign_redirect: got v=%b f=%b addr=%h cnt=%0d, required v=0 f=0 addr=102 cnt=5",
               inst_valid, fault, rom_addr, fetch_count);
    end
    redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (fault !== 1'b1 || inst_valid !== 1'b0 || rom_addr !== 32'h102 || fetch_count !== 32'd5) begin
        n_errors++;
        $display("FAIL misalign_fault[%0d]: got f=%b v=%b addr=%h cnt=%0d, required f=1 v=0 addr=102 cnt=5",
                 i, fault, inst_valid, rom_addr, fetch_count);
      end
    end
    redirect_valid = 1'b1; redirect_pc = 32'h0;
    tick();
    n_checks++;
    if (fault !== 1'b0 || inst_valid !== 1'b0 || rom_addr !== 32'h0) begin
      n_errors++;
      $display("FAIL fault_clear: got f=%b v=%b addr=%h, required f=0 v=0 addr=0", fault, inst_valid, rom_addr);
    end
    redirect_valid = 1'b0;
    push_exp(32'h0);
    tick();
    n_checks++;
    if (inst_valid !== 1'b1 || inst !== 32'hC000_0937 || inst_pc !== 32'h0 || fetch_count !== 32'd5) begin
      n_errors++;
      $display("FAIL fault_recover: got v=%b inst=%h pc=%h cnt=%0d, required v=1 inst=c0000937 pc=0 cnt=5",
               inst_valid, inst, inst_pc, fetch_count);
    end
  endtask

  task automatic test_range_end();
    redirect_valid = 1'b1; redirect_pc = 32'hFC;  // flushes the word at 0x0
    tick();
    n_checks++;
    if (inst_valid !== 1'b0 || rom_addr !== 32'hFC || fetch_count !== 32'd6) begin
      n_errors++;
      $display("FAIL end_redirect: got v=%b addr=%h cnt=%0d, required v=0 addr=fc cnt=6",
               inst_valid, rom_addr, fetch_count);
    end
    redirect_valid = 1'b0;
    push_exp(32'hFC);
    tick();
    n_checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'hFC || rom_addr !== 32'h100 || fault !== 1'b0) begin
      n_errors++;
      $display("FAIL last_word: got v=%b pc=%h addr=%h f=%b, required v=1 pc=fc addr=100 f=0",
               inst_valid, inst_pc, rom_addr, fault);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (fault !== 1'b1 || inst_valid !== 1'b0 || rom_addr !== 32'h100 || fetch_count !== 32'd7) begin
        n_errors++;
        $display("FAIL range_fault[%0d]: got f=%b v=%b addr=%h cnt=%0d, required f=1 v=0 addr=100 cnt=7",
                 i, fault, inst_valid, rom_addr, fetch_count);
      end
    end
    n_checks++;
    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL sb_drained: got %0d entries pending, required 0", sb_q.size());
    end
  endtask

  task automatic test_reset_midrun();
    redirect_valid = 1'b1; redirect_pc = 32'h20;
    tick();
    redirect_valid = 1'b0;
    tick();
    n_checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h20) begin
      n_errors++;
      $display("FAIL pre_reset: got v=%b pc=%h, required v=1 pc=20", inst_valid, inst_pc);
    end
    push_exp(32'h20);
    rst_n = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h80; inst_ready = 1'b1;
    tick();
    n_checks++;
    if ({inst_valid, fault, inst, inst_pc, fetch_count, rom_addr} !== {2'b00, 128'h0}) begin
      n_errors++;
      $display("FAIL reset_midrun: got v=%b f=%b inst=%h pc=%h cnt=%0d addr=%h, required all zero",
               inst_valid, fault, inst, inst_pc, fetch_count, rom_addr);
    end
    redirect_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic        prev_stall;
    logic [31:0] prev_inst, prev_pc, prev_addr;
    int          popped_at_start;
    popped_at_start = n_popped;
    for (int i = 0; i < 40; i++) push_exp(32'(i * 4));
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      inst_ready = 1'($urandom_range(0, 1));
      prev_stall = (inst_valid === 1'b1) && !inst_ready;
      prev_inst  = inst;
      prev_pc    = inst_pc;
      prev_addr  = rom_addr;
      tick();
      if (prev_stall) begin
        n_checks++;
        if (inst_valid !== 1'b1 || inst !== prev_inst || inst_pc !== prev_pc || rom_addr !== prev_addr) begin
          n_errors++;
          $display("FAIL b2b_stall[%0d]: got v=%b inst=%h pc=%h addr=%h, required v=1 inst=%h pc=%h addr=%h",
                   i, inst_valid, inst, inst_pc, rom_addr, prev_inst, prev_pc, prev_addr);
        end
      end
    end
    n_checks++;
    if (fetch_count !== 32'(n_popped - popped_at_start)) begin
      n_errors++;
      $display("FAIL b2b_count: got %0d, required %0d", fetch_count, n_popped - popped_at_start);
    end
    sb_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_boot_stream();
    test_stall();
    test_redirect();
    test_misaligned_fault();
    test_range_end();
    test_reset_midrun();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
